// File: rtl/td_mux_pkg.sv
// td_mux_pkg: shared definitions for the TD subsystem read-data selectors.
//
// Contents:
//   ONEHOT_MUX_MAX_N  largest supported channel count
//   ONEHOT_MUX_CNT_W  default width of the invalid-select error counter
//   idx_w()           width of an encoded channel index for n channels
//   pipe_state_e      occupancy of the single-stage output register
package td_mux_pkg;

  localparam int ONEHOT_MUX_MAX_N = 32;
  localparam int ONEHOT_MUX_CNT_W = 8;

  // $clog2 wrapper that never returns 0, so a 1-channel or 2-channel index
  // still has a real bit to live in.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    PIPE_EMPTY = 1'b0,
    PIPE_FULL  = 1'b1
  } pipe_state_e;

endpackage

// File: rtl/onehot_mux_pipe_if.sv
// onehot_mux_pipe_if: transaction bus of the registered one-hot selector.
//
// Signals:
//   in_valid/in_ready     input handshake; sel, sig_in, sig_default ride on it
//   out_valid/out_ready   output handshake; sig_out, out_idx, out_err ride on it
//   err_cnt/err_clr       invalid-select counter and its synchronous clear
//   state                 occupancy of the output register (debug view)
//
// Handshake rule (both sides): a transfer happens on a rising clock edge
// where valid and ready are both high. A producer holding valid keeps its
// payload stable until that edge; ready may depend combinationally on the
// consumer's state but never on the same side's valid.
//
// Modports: master = producer of input transactions and consumer of output
// transactions (the surrounding logic); slave = the selector itself.
interface onehot_mux_pipe_if
  import td_mux_pkg::*;
#(
  parameter int N     = 16,
  parameter int WIDTH = 1,
  parameter int CNT_W = ONEHOT_MUX_CNT_W,
  localparam int IDX_W = idx_w(N)
) ();

  logic               in_valid;
  logic               in_ready;
  logic [N-1:0]       sel;
  logic [N*WIDTH-1:0] sig_in;
  logic [WIDTH-1:0]   sig_default;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   sig_out;
  logic [IDX_W-1:0]   out_idx;
  logic               out_err;
  logic [CNT_W-1:0]   err_cnt;
  logic               err_clr;
  pipe_state_e        state;

  modport master (
    output in_valid, sel, sig_in, sig_default, out_ready, err_clr,
    input  in_ready, out_valid, sig_out, out_idx, out_err, err_cnt, state
  );

  modport slave (
    input  in_valid, sel, sig_in, sig_default, out_ready, err_clr,
    output in_ready, out_valid, sig_out, out_idx, out_err, err_cnt, state
  );

endinterface

// File: rtl/onehot_mux_pipe_decode.sv
// onehot_decode: combinational analysis of an N-bit select vector.
//
// Ports:
//   sel         in   N      select vector, bit k = channel k
//   is_onehot   out  1      exactly one bit set
//   any_set     out  1      at least one bit set
//   idx         out  IDX_W  index of the set bit when one-hot, else 0
//   lowest_idx  out  IDX_W  index of the lowest set bit, 0 when none set
module onehot_decode
  import td_mux_pkg::*;
#(
  parameter int N = 16,
  localparam int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     sel,
  output logic             is_onehot,
  output logic             any_set,
  output logic [IDX_W-1:0] idx,
  output logic [IDX_W-1:0] lowest_idx
);

  logic [IDX_W-1:0] or_idx;

  always_comb begin
    or_idx     = '0;
    lowest_idx = '0;
    // Scanning downward leaves the lowest set position as the final winner.
    for (int k = N - 1; k >= 0; k--) begin
      if (sel[k]) lowest_idx = IDX_W'(k);
    end
    // OR-encoding is exact for a one-hot vector and cheaper than a priority
    // chain; it is masked below whenever the vector is not one-hot.
    for (int k = 0; k < N; k++) begin
      if (sel[k]) or_idx = or_idx | IDX_W'(k);
    end
  end

  assign any_set   = |sel;
  // Clearing the lowest set bit leaves nothing only for a power of two.
  assign is_onehot = any_set && ((sel & (sel - N'(1))) == '0);
  assign idx       = is_onehot ? or_idx : '0;

endmodule

// File: rtl/onehot_mux_pipe.sv
// onehot_mux_pipe: registered one-hot N:1 selector with valid/ready flow
// control, encoded index output and a saturating invalid-select counter.
//
// Ports:
//   clk    in   system clock, rising edge
//   rstn   in   asynchronous active-low reset
//   bus    slave modport of onehot_mux_pipe_if (handshakes, data, counter)
//
// Build option: ONEHOT_MUX_PRIO_FALLBACK_EN
//   defined   - a multi-hot select routes the lowest set channel and reports
//               its index (out_err still flags it, err_cnt still counts it)
//   undefined - any non-one-hot select outputs sig_default with index 0
module onehot_mux_pipe
  import td_mux_pkg::*;
#(
  parameter int N     = 16,
  parameter int WIDTH = 1,
  parameter int CNT_W = ONEHOT_MUX_CNT_W,
  localparam int IDX_W = idx_w(N)
) (
  input logic              clk,
  input logic              rstn,
  onehot_mux_pipe_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  pipe_state_e      state_q, state_d;
  logic             in_ready;
  logic             acc;

  logic             is_onehot;
  logic             any_set;
  logic [IDX_W-1:0] dec_idx;
  logic [IDX_W-1:0] lowest_idx;

  logic             use_ch;
  logic [IDX_W-1:0] mux_idx;
  logic [IDX_W-1:0] nxt_idx;
  logic [WIDTH-1:0] nxt_data;

  logic [WIDTH-1:0] sig_out_q;
  logic [IDX_W-1:0] out_idx_q;
  logic             out_err_q;
  logic [CNT_W-1:0] err_cnt_q;

  onehot_decode #(.N(N)) u_decode (
    .sel        (bus.sel),
    .is_onehot  (is_onehot),
    .any_set    (any_set),
    .idx        (dec_idx),
    .lowest_idx (lowest_idx)
  );

  // Single-stage pipe: the register can take a new word when it is empty or
  // when its current word leaves on this same edge.
  assign in_ready = (state_q == PIPE_EMPTY) || bus.out_ready;
  assign acc      = bus.in_valid && in_ready;

`ifdef ONEHOT_MUX_PRIO_FALLBACK_EN
  assign use_ch  = any_set;
  assign mux_idx = lowest_idx;
  assign nxt_idx = is_onehot ? dec_idx : lowest_idx;
`else
  // any_set is implied by is_onehot; kept explicit so the decode intent reads
  // the same in both builds.
  assign use_ch  = any_set && is_onehot;
  // For a one-hot vector the lowest set bit is the only set bit.
  assign mux_idx = lowest_idx;
  assign nxt_idx = dec_idx;
`endif

  always_comb begin
    nxt_data = bus.sig_default;
    if (use_ch) begin
      for (int k = 0; k < N; k++) begin
        if (mux_idx == IDX_W'(k)) nxt_data = bus.sig_in[k*WIDTH +: WIDTH];
      end
    end
  end

  // Occupancy FSM: FULL stays FULL on a refill, empties only on a drain
  // with nothing new arriving.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PIPE_EMPTY: if (acc) state_d = PIPE_FULL;
      PIPE_FULL:  if (bus.out_ready && !bus.in_valid) state_d = PIPE_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= PIPE_EMPTY;
    else       state_q <= state_d;
  end

  // Payload only moves on accept; a drain leaves the last word in place.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sig_out_q <= '0;
      out_idx_q <= '0;
      out_err_q <= 1'b0;
    end else if (acc) begin
      sig_out_q <= nxt_data;
      out_idx_q <= nxt_idx;
      out_err_q <= !is_onehot;
    end
  end

  // Clear wins over a coincident invalid accept; that event is dropped.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_cnt_q <= '0;
    end else if (bus.err_clr) begin
      err_cnt_q <= '0;
    end else if (acc && !is_onehot && (err_cnt_q != CNT_MAX)) begin
      err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == PIPE_FULL);
  assign bus.sig_out   = sig_out_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_err   = out_err_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_onehot_mux_pipe.sv
// tb_onehot_mux_pipe: three selector configurations run side by side:
//   g0: N=16, WIDTH=8, CNT_W=2  (directed streaming, stall, invalid select,
//                                counter saturation/clear, then random)
//   g1: N=2,  WIDTH=1, CNT_W=8  (random)
//   g2: N=32, WIDTH=1, CNT_W=8  (random)
// Each configuration gets a mid-transaction asynchronous reset. Expected
// outputs come from a popcount/lowest-set-bit model; a negedge monitor
// compares them against whatever the DUT presents.
module tb_onehot_mux_pipe;
  import td_mux_pkg::*;

  typedef struct packed {
    logic [31:0] sel;
    logic        vld;
    logic        ordy;
    logic        clr;
  } stim_t;

  logic       clk;
  int         checks = 0;
  int         errors = 0;
  wire  [2:0] done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Clock / reset block (resets are per configuration, below)
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int NN = (g == 0) ? 16 : ((g == 1) ? 2 : 32);
    localparam int WW = (g == 0) ? 8 : 1;
    localparam int CW = (g == 0) ? 2 : 8;
    localparam int IW = idx_w(NN);
    localparam int EW = WW + IW + 1;

    logic          rstn_l;
    logic          done_l;
    logic [EW-1:0] exp_q[$];
    int            cnt_m;

    onehot_mux_pipe_if #(.N(NN), .WIDTH(WW), .CNT_W(CW)) bus ();

    onehot_mux_pipe #(.N(NN), .WIDTH(WW), .CNT_W(CW)) dut (
      .clk  (clk),
      .rstn (rstn_l),
      .bus  (bus)
    );

    assign done[g] = done_l;

    // Driver: inputs change 1 time unit after each rising edge.
    initial begin : drv
      stim_t        tbl[$];
      logic [127:0] wide;
      int           r;
      rstn_l          = 1'b0;
      done_l          = 1'b0;
      bus.in_valid    = 1'b0;
      bus.sel         = '0;
      bus.sig_in      = '0;
      bus.sig_default = '0;
      bus.out_ready   = 1'b0;
      bus.err_clr     = 1'b0;
      repeat (3) @(posedge clk);
      #1 rstn_l = 1'b1;

      if (g == 0) begin
        for (int k = 0; k < NN; k++) bus.sig_in[k*WW +: WW] = WW'(8'hA0 + k);
        bus.sig_default = WW'(8'h5A);
        // full-rate streaming over every channel
        for (int k = 0; k < 16; k++) tbl.push_back({32'd1 << k, 1'b1, 1'b1, 1'b0});
        tbl.push_back({32'd0, 1'b0, 1'b1, 1'b0});
        // accept ch3, stall 3 cycles with changing sel, then release
        tbl.push_back({32'd1 << 3, 1'b1, 1'b1, 1'b0});
        tbl.push_back({32'd1 << 4, 1'b1, 1'b0, 1'b0});
        tbl.push_back({32'd1 << 5, 1'b1, 1'b0, 1'b0});
        tbl.push_back({32'd1 << 6, 1'b1, 1'b0, 1'b0});
        tbl.push_back({32'd1 << 7, 1'b1, 1'b1, 1'b0});
        tbl.push_back({32'd0, 1'b0, 1'b1, 1'b0});
        // zero-hot then multi-hot
        tbl.push_back({32'd0, 1'b1, 1'b1, 1'b0});
        tbl.push_back({32'h0006, 1'b1, 1'b1, 1'b0});
        // five more invalid accepts drive the 2-bit counter into saturation
        tbl.push_back({32'hFFFF, 1'b1, 1'b1, 1'b0});
        tbl.push_back({32'd0, 1'b1, 1'b1, 1'b0});
        tbl.push_back({32'h8001, 1'b1, 1'b1, 1'b0});
        tbl.push_back({32'd0, 1'b1, 1'b1, 1'b0});
        tbl.push_back({32'h0030, 1'b1, 1'b1, 1'b0});
        tbl.push_back({32'd0, 1'b0, 1'b1, 1'b0});
        // clear with a coincident invalid accept, then count once more
        tbl.push_back({32'h0003, 1'b1, 1'b1, 1'b1});
        tbl.push_back({32'd0, 1'b0, 1'b1, 1'b0});
        tbl.push_back({32'd0, 1'b1, 1'b1, 1'b0});
        tbl.push_back({32'd0, 1'b0, 1'b1, 1'b0});
        foreach (tbl[i]) begin
          bus.sel       = NN'(tbl[i].sel);
          bus.in_valid  = tbl[i].vld;
          bus.out_ready = tbl[i].ordy;
          bus.err_clr   = tbl[i].clr;
          @(posedge clk);
          #1;
        end
      end

      // Mid-transaction reset: load a word, hold it, then pull rstn.
      bus.sel       = NN'(1);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      bus.err_clr   = 1'b0;
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #2 rstn_l = 1'b0;
      #1;
      check($sformatf("g%0d rst out_valid", g), 64'(bus.out_valid), 64'd0);
      check($sformatf("g%0d rst sig_out", g), 64'(bus.sig_out), 64'd0);
      check($sformatf("g%0d rst out_idx", g), 64'(bus.out_idx), 64'd0);
      check($sformatf("g%0d rst out_err", g), 64'(bus.out_err), 64'd0);
      check($sformatf("g%0d rst err_cnt", g), 64'(bus.err_cnt), 64'd0);
      check($sformatf("g%0d rst in_ready", g), 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      @(posedge clk);
      #1 rstn_l = 1'b1;

      // Random traffic
      for (int c = 0; c < 400; c++) begin
        wide            = {$urandom, $urandom, $urandom, $urandom};
        bus.sig_in      = wide[NN*WW-1:0];
        bus.sig_default = WW'($urandom);
        r = $urandom_range(0, 9);
        if (r == 0)      bus.sel = '0;
        else if (r == 1) bus.sel = NN'($urandom);
        else             bus.sel = NN'(1) << $urandom_range(0, NN - 1);
        bus.in_valid  = ($urandom_range(0, 3) != 0);
        bus.out_ready = ($urandom_range(0, 3) != 0);
        bus.err_clr   = ($urandom_range(0, 30) == 0);
        @(posedge clk);
        #1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.err_clr   = 1'b0;
      repeat (3) @(posedge clk);
      done_l = 1'b1;
    end

    // Scoreboard / monitor: at each falling edge, first compare what the DUT
    // presents, then predict what the next rising edge will do.
    always @(negedge clk) begin : mon
      int            ones;
      int            low;
      logic          use_ch;
      logic          room;
      logic          err_v;
      logic [WW-1:0] dat;
      logic [IW-1:0] iv;
      logic [EW-1:0] e;
      if (!rstn_l) begin
        exp_q.delete();
        cnt_m = 0;
      end else begin
        room = (exp_q.size() == 0) || bus.out_ready;
        check($sformatf("g%0d out_valid", g), 64'(bus.out_valid), 64'(exp_q.size() != 0));
        check($sformatf("g%0d in_ready", g), 64'(bus.in_ready), 64'(room));
        check($sformatf("g%0d err_cnt", g), 64'(bus.err_cnt), 64'(cnt_m));
        if (exp_q.size() != 0) begin
          e = exp_q[0];
          check($sformatf("g%0d sig_out", g), 64'(bus.sig_out), 64'(e[EW-1 -: WW]));
          check($sformatf("g%0d out_idx", g), 64'(bus.out_idx), 64'(e[IW:1]));
          check($sformatf("g%0d out_err", g), 64'(bus.out_err), 64'(e[0]));
          if (bus.out_ready) void'(exp_q.pop_front());
        end

        ones = $countones(bus.sel);
        low  = -1;
        for (int k = NN - 1; k >= 0; k--) if (bus.sel[k]) low = k;
`ifdef ONEHOT_MUX_PRIO_FALLBACK_EN
        use_ch = (ones >= 1);
`else
        use_ch = (ones == 1);
`endif
        if (use_ch) begin
          dat = bus.sig_in[low*WW +: WW];
          iv  = IW'(low);
        end else begin
          dat = bus.sig_default;
          iv  = '0;
        end
        err_v = (ones != 1);
        if (bus.in_valid && room) exp_q.push_back({dat, iv, err_v});

        if (bus.err_clr) cnt_m = 0;
        else if (bus.in_valid && room && err_v && cnt_m < (1 << CW) - 1) cnt_m++;
      end
    end
  end

  // Final report
  initial begin
    for (int i = 0; i < 20000 && done !== 3'b111; i++) @(posedge clk);
    check("all_done", 64'(done), 64'd7);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/onehot_mux_pipe.md
Name: onehot_mux_pipe

Overview:
- Parametrised, registered one-hot N:1 selector with valid/ready flow control.
- Successor to the fixed 16-way combinational one-hot select.
- Adds generic channel count, an output pipeline register with backpressure, encoded index output, invalid-select detection and a saturating error counter.
- Sits between peripheral read-data sources and the bus/graphics consumers in the TD subsystem.

Parameters:
- N, 16, number of input channels (2..32).
- WIDTH, 1, bits per channel.
- CNT_W, 8, width of the invalid-select error counter.
- IDX_W, $clog2(N), width of the encoded index (derived; not overridable).

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  sel/sig_in/sig_default are valid this cycle.
- in_ready  out  1  block can accept a transaction this cycle.
- sel  in  N  one-hot channel select; bit k selects channel k.
- sig_in  in  N*WIDTH  packed channels; channel k = sig_in[(k+1)*WIDTH-1 : k*WIDTH].
- sig_default  in  WIDTH  value output when sel is not one-hot.
- out_valid  out  1  output register holds a transaction.
- out_ready  in  1  consumer accepts the output this cycle.
- sig_out  out  WIDTH  registered selected data.
- out_idx  out  IDX_W  encoded index of the selected channel; 0 when invalid.
- out_err  out  1  transaction had a zero-hot or multi-hot sel.
- err_cnt  out  CNT_W  saturating count of accepted invalid-select transactions.
- err_clr  in  1  synchronous clear of err_cnt.

Behaviour:
- Reset (rstn low, async): out_valid=0, sig_out=0, out_idx=0, out_err=0, err_cnt=0.
  - in_ready reads 1 in reset, since it is combinational from out_valid.
  - A mid-transaction reset drops the held output with no handshake.
- in_ready = !out_valid || out_ready (combinational; single-stage pipe, no skid buffer).
- Accept condition: acc = in_valid && in_ready. On acc at edge t, at t+1:
  - out_valid=1.
  - sig_out = channel k if sel == (1<<k); otherwise sig_default.
  - out_idx = k if one-hot, else 0.
  - out_err = !onehot(sel).
- Latency: exactly 1 cycle from accept to out_valid.
- Throughput: 1 transaction/cycle while out_ready is held high.
- Drain without refill: out_valid && out_ready && !in_valid -> out_valid=0 next cycle. sig_out/out_idx/out_err hold their last values.
- Stall: out_valid && !out_ready -> all outputs hold; in_ready=0; inputs are ignored.
- One-hot check: popcount(sel)==1. sel==0 and multi-hot are both invalid.
- sel bits at positions >= N do not exist; the width is exactly N.
- err_cnt:
  - Increments by 1 on each acc with invalid sel.
  - Saturates at 2^CNT_W-1 and never wraps.
  - err_clr has priority: if err_clr and an invalid acc occur in the same cycle, err_cnt becomes 0 (the event is lost).
- Inputs are sampled only on acc. Changes to sel/sig_in while a transaction is held have no effect on the outputs.
- No internal state other than the output register and err_cnt. No FSM beyond the out_valid flag (EMPTY/FULL).

Optional Feature:
- Macro: ONEHOT_MUX_PRIO_FALLBACK_EN.
- Defined: on a multi-hot sel, sig_out/out_idx take the lowest set index; out_err is still 1 and err_cnt still increments. Zero-hot still yields sig_default, idx 0.
- Undefined: multi-hot yields sig_default, idx 0 (baseline behaviour above).

Decomposition:
- Shared package/header `td_mux_pkg`:
  - localparam helper for IDX_W ($clog2 wrapper).
  - Constant ONEHOT_MUX_MAX_N = 32.
  - Error-counter width default.
- One natural sub-module: onehot_decode.
  - Purely combinational, parametrised N.
  - Outputs is_onehot, idx (IDX_W), lowest_idx and any_set.
  - Instantiated once, feeding the data mux and the register stage.

Test Plan:
1. Reset then idle:
   - Stimulus: rstn low mid-stream with out_valid=1.
   - Required: out_valid=0, sig_out=0, err_cnt=0 immediately; in_ready=1.
2. Full-rate streaming:
   - Stimulus: N=16, WIDTH=8, sig_in channel k = 8'hA0+k, sel cycles 1<<0..1<<15, out_ready=1.
   - Required: one output per cycle, sig_out = A0..AF in order, out_idx 0..15, out_err=0.
3. Backpressure:
   - Stimulus: out_ready=0 for 3 cycles after the first accept, while sel and data keep changing.
   - Required: in_ready=0; sig_out holds the first value; no input is consumed until out_ready=1.
4. Invalid select:
   - Stimulus: sel=0 with sig_default=8'h5A, then sel=16'h0006.
   - Required: sig_out=5A both times, out_err=1, out_idx=0, err_cnt=2.
   - With ONEHOT_MUX_PRIO_FALLBACK_EN: second output = channel 1 (A1), idx 1, out_err=1.
5. Counter saturation and clear:
   - Stimulus: CNT_W=2, 5 invalid accepts.
   - Required: err_cnt=3 and stays at 3.
   - Then err_clr with a simultaneous invalid accept -> err_cnt=0.
6. Scaling:
   - Stimulus: N=2 and N=32, WIDTH=1, random one-hot select.
   - Required: matches the reference model every cycle; IDX_W=1 and 5 respectively.
